spi_word_slave: RTL and testbench

SPI_WORD_SLAVE -- requirements
Module: spi_word_slave

---
 rtl/spi_word_slave.sv | 176 +++++++++++++++++
 tb/tb_spi_word_slave.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_word_slave.sv
// SPI word slave: synchronised pins, all four modes, selectable bit order.
// Holding register feeds tx; IDLE_WORD and a sticky underrun when it is empty.
`timescale 1ns/1ps
module spi_word_slave #(
  parameter int WIDTH = 8,
  parameter int CPOL = 0,
  parameter int CPHA = 0,
  parameter int MSB_FIRST = 1,
  parameter int SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] IDLE_WORD = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_clk,
  input  logic             spi_cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic             tx_underrun,
  output logic             frame_active
);

  localparam int CW = $clog2(WIDTH);
  localparam int S = SYNC_STAGES;
  localparam logic CPOL_B = (CPOL != 0);
  localparam logic CPHA_B = (CPHA != 0);
  localparam logic MSB_B = (MSB_FIRST != 0);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [2:0] FLUSH = 3'(S + 1);

  logic [S-1:0] sclk_sync_q, sclk_sync_d;
  logic [S-1:0] cs_sync_q, cs_sync_d;
  logic [S-1:0] mosi_sync_q, mosi_sync_d;
  logic sclk_prev_q, sclk_prev_d;
  logic cs_prev_q, cs_prev_d;
  logic [2:0] flush_q, flush_d;
  logic armed_q, armed_d;
  logic frame_q, frame_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic hold_full_q, hold_full_d;
  logic under_q, under_d;
  logic done_q, done_d;
  logic rx_valid_q, rx_valid_d;

  logic sclk_s, cs_s, mosi_s;
  logic rise, fall, lead, trail;
  logic sample_e, shift_e, cs_fall;
  logic flushed, act, reload, tx_bit;

  assign sclk_s = sclk_sync_q[S-1];
  assign cs_s = cs_sync_q[S-1];
  assign mosi_s = mosi_sync_q[S-1];
  assign rise = sclk_s & ~sclk_prev_q;
  assign fall = ~sclk_s & sclk_prev_q;
  assign lead = CPOL_B ? fall : rise;
  assign trail = CPOL_B ? rise : fall;
  assign sample_e = CPHA_B ? trail : lead;
  assign shift_e = CPHA_B ? lead : trail;
  assign cs_fall = ~cs_s & cs_prev_q;
  // Pins are trusted only once the chains hold sampled values.
  assign flushed = (flush_q == FLUSH);
  assign act = frame_q & ~cs_s;
  assign tx_bit = MSB_B ? tx_sh_q[WIDTH-1] : tx_sh_q[0];

  always_comb begin
    sclk_sync_d = {sclk_sync_q[S-2:0], spi_clk};
    cs_sync_d = {cs_sync_q[S-2:0], spi_cs_n};
    mosi_sync_d = {mosi_sync_q[S-2:0], mosi};
    sclk_prev_d = sclk_s;
    cs_prev_d = cs_s;
    flush_d = flushed ? flush_q : flush_q + 3'd1;
    armed_d = armed_q | (flushed & cs_s);
    frame_d = ~cs_s & (frame_q | (cs_fall & armed_q));
    cnt_d = cnt_q;
    rx_sh_d = rx_sh_q;
    tx_sh_d = tx_sh_q;
    hold_d = hold_q;
    hold_full_d = hold_full_q;
    under_d = under_q;
    done_d = 1'b0;
    rx_valid_d = done_q;
    rx_data_d = done_q ? rx_sh_q : rx_data_q;
    reload = cs_fall & armed_q;
    if (act) begin
      if (sample_e) begin
        rx_sh_d = MSB_B ? {rx_sh_q[WIDTH-2:0], mosi_s}
                        : {mosi_s, rx_sh_q[WIDTH-1:1]};
        if (cnt_q == LAST) begin
          cnt_d = '0;
          done_d = 1'b1;
          reload = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else if (shift_e && cnt_q != '0) begin
        tx_sh_d = MSB_B ? {tx_sh_q[WIDTH-2:0], 1'b0}
                        : {1'b0, tx_sh_q[WIDTH-1:1]};
      end
    end else begin
      cnt_d = '0;
    end
    if (reload) begin
      if (hold_full_q) begin
        tx_sh_d = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_sh_d = IDLE_WORD;
        under_d = 1'b1;
      end
    end
    // A load racing an empty reload is kept for the following word.
    if (tx_load && !hold_full_q) begin
      hold_d = tx_data;
      hold_full_d = 1'b1;
      if (!reload) under_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= {S{CPOL_B}};
      cs_sync_q <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= CPOL_B;
      cs_prev_q <= 1'b1;
      flush_q <= '0;
      armed_q <= 1'b0;
      frame_q <= 1'b0;
      cnt_q <= '0;
      rx_sh_q <= '0;
      tx_sh_q <= '0;
      hold_q <= '0;
      rx_data_q <= '0;
      hold_full_q <= 1'b0;
      under_q <= 1'b0;
      done_q <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q <= cs_prev_d;
      flush_q <= flush_d;
      armed_q <= armed_d;
      frame_q <= frame_d;
      cnt_q <= cnt_d;
      rx_sh_q <= rx_sh_d;
      tx_sh_q <= tx_sh_d;
      hold_q <= hold_d;
      rx_data_q <= rx_data_d;
      hold_full_q <= hold_full_d;
      under_q <= under_d;
      done_q <= done_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign miso = frame_q & tx_bit;
  assign miso_oe = frame_q;
  assign frame_active = frame_q;
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_ready = ~hold_full_q;
  assign tx_underrun = under_q;

endmodule

// File: tb/tb_spi_word_slave.sv
// Directed bench for spi_word_slave: six instances covering modes,
// bit order and 16-bit words, driven by one bit-banged SPI master.
`timescale 1ns/1ps
module tb_spi_word_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk0 = 1'b0;
  logic sclk1;
  logic mosi = 1'b0;
  logic [5:0] cs_n = 6'h3f;
  logic [5:0] tx_load = 6'h0;
  logic [31:0] tx_data = '0;

  logic miso [6];
  logic moe [6];
  logic rxv [6];
  logic txr [6];
  logic und [6];
  logic fra [6];
  logic [7:0] rxd8 [5];
  logic [15:0] rxd16;

  int n_err = 0;
  int n_chk = 0;
  int vcnt [6] = '{default: 0};
  logic [15:0] w16_log [$];
  logic [31:0] mtx [4];
  logic [31:0] mrx [4];

  assign sclk1 = ~sclk0;
  always #5 clk = ~clk;

  spi_word_slave #(.CPOL(0), .CPHA(0)) u_m0 (
    .clk(clk), .rst(rst), .spi_clk(sclk0), .spi_cs_n(cs_n[0]),
    .mosi(mosi), .miso(miso[0]), .miso_oe(moe[0]),
    .rx_data(rxd8[0]), .rx_valid(rxv[0]), .tx_data(tx_data[7:0]),
    .tx_load(tx_load[0]), .tx_ready(txr[0]), .tx_underrun(und[0]),
    .frame_active(fra[0]));

  spi_word_slave #(.CPOL(0), .CPHA(1)) u_m1 (
    .clk(clk), .rst(rst), .spi_clk(sclk0), .spi_cs_n(cs_n[1]),
    .mosi(mosi), .miso(miso[1]), .miso_oe(moe[1]),
    .rx_data(rxd8[1]), .rx_valid(rxv[1]), .tx_data(tx_data[7:0]),
    .tx_load(tx_load[1]), .tx_ready(txr[1]), .tx_underrun(und[1]),
    .frame_active(fra[1]));

  spi_word_slave #(.CPOL(1), .CPHA(0)) u_m2 (
    .clk(clk), .rst(rst), .spi_clk(sclk1), .spi_cs_n(cs_n[2]),
    .mosi(mosi), .miso(miso[2]), .miso_oe(moe[2]),
    .rx_data(rxd8[2]), .rx_valid(rxv[2]), .tx_data(tx_data[7:0]),
    .tx_load(tx_load[2]), .tx_ready(txr[2]), .tx_underrun(und[2]),
    .frame_active(fra[2]));

  spi_word_slave #(.CPOL(1), .CPHA(1)) u_m3 (
    .clk(clk), .rst(rst), .spi_clk(sclk1), .spi_cs_n(cs_n[3]),
    .mosi(mosi), .miso(miso[3]), .miso_oe(moe[3]),
    .rx_data(rxd8[3]), .rx_valid(rxv[3]), .tx_data(tx_data[7:0]),
    .tx_load(tx_load[3]), .tx_ready(txr[3]), .tx_underrun(und[3]),
    .frame_active(fra[3]));

  spi_word_slave #(.MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .spi_clk(sclk0), .spi_cs_n(cs_n[4]),
    .mosi(mosi), .miso(miso[4]), .miso_oe(moe[4]),
    .rx_data(rxd8[4]), .rx_valid(rxv[4]), .tx_data(tx_data[7:0]),
    .tx_load(tx_load[4]), .tx_ready(txr[4]), .tx_underrun(und[4]),
    .frame_active(fra[4]));

  spi_word_slave #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .spi_clk(sclk0), .spi_cs_n(cs_n[5]),
    .mosi(mosi), .miso(miso[5]), .miso_oe(moe[5]),
    .rx_data(rxd16), .rx_valid(rxv[5]), .tx_data(tx_data[15:0]),
    .tx_load(tx_load[5]), .tx_ready(txr[5]), .tx_underrun(und[5]),
    .frame_active(fra[5]));

  always @(negedge clk) begin
    for (int k = 0; k < 6; k++)
      if (rxv[k] === 1'b1) vcnt[k]++;
    if (rxv[5] === 1'b1) w16_log.push_back(rxd16);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic hw();
    repeat (4) @(negedge clk);
  endtask

  task automatic load(input int idx, input logic [31:0] v);
    @(negedge clk);
    tx_data = v;
    tx_load[idx] = 1'b1;
    @(negedge clk);
    tx_load[idx] = 1'b0;
  endtask

  task automatic xfer(input int idx, input bit cpha, input int w,
                      input bit msb, input logic [31:0] tx,
                      input int nb, output logic [31:0] rx);
    int b;
    rx = '0;
    for (int i = 0; i < nb; i++) begin
      b = msb ? w - 1 - i : i;
      if (!cpha) begin
        mosi = tx[b];
        hw();
        rx[b] = miso[idx];
        sclk0 = 1'b1;
        hw();
        sclk0 = 1'b0;
      end else begin
        sclk0 = 1'b1;
        mosi = tx[b];
        hw();
        rx[b] = miso[idx];
        sclk0 = 1'b0;
        hw();
      end
    end
  endtask

  task automatic frame(input int idx, input bit cpha, input int w,
                       input bit msb, input int nw, input int nb);
    logic [31:0] r;
    cs_n[idx] = 1'b0;
    hw();
    for (int j = 0; j < nw; j++) begin
      xfer(idx, cpha, w, msb, mtx[j], nb, r);
      mrx[j] = r;
    end
    hw();
    cs_n[idx] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic feed_w16();
    logic [31:0] nxt [3];
    int t;
    nxt = '{32'h1357, 32'h8001, 32'h0000};
    for (int j = 0; j < 3; j++) begin
      t = 0;
      while (txr[5] !== 1'b1 && t < 3000) begin
        @(negedge clk);
        t++;
      end
      check("w16_ready_wait", 32'(t < 3000), 32'd1);
      load(5, nxt[j]);
    end
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, "_rx_valid"}, 32'(rxv[0]), 32'd0);
    check({tag, "_rx_data"}, 32'(rxd8[0]), 32'd0);
    check({tag, "_tx_ready"}, 32'(txr[0]), 32'd1);
    check({tag, "_underrun"}, 32'(und[0]), 32'd0);
    check({tag, "_frame"}, 32'(fra[0]), 32'd0);
    check({tag, "_miso_oe"}, 32'(moe[0]), 32'd0);
    check({tag, "_miso"}, 32'(miso[0]), 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c0;
    logic [31:0] r;
    logic [7:0] stx [2];
    logic [7:0] mv [2];
    bit cpha;

    repeat (4) @(negedge clk);
    reset_outputs("rst");
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Mode 0 basic word
    load(0, 32'hA5);
    check("m0_ready_after_load", 32'(txr[0]), 32'd0);
    mtx[0] = 32'h3C;
    c0 = vcnt[0];
    frame(0, 1'b0, 8, 1'b1, 1, 8);
    check("m0_rx_data", 32'(rxd8[0]), 32'h3C);
    check("m0_rx_valid_cnt", 32'(vcnt[0] - c0), 32'd1);
    check("m0_master_rx", mrx[0], 32'hA5);
    check("m0_ready_back", 32'(txr[0]), 32'd1);
    check("m0_underrun_end", 32'(und[0]), 32'd1);

    // Other modes and LSB-first
    stx = '{8'h81, 8'h35};
    mv = '{8'h81, 8'hC6};
    for (int idx = 1; idx <= 4; idx++) begin
      cpha = (idx == 1 || idx == 3);
      for (int v = 0; v < 2; v++) begin
        load(idx, 32'(stx[v]));
        mtx[0] = 32'(mv[v]);
        c0 = vcnt[idx];
        frame(idx, cpha, 8, idx != 4, 1, 8);
        check($sformatf("mode%0d_rx_%0d", idx, v),
              32'(rxd8[idx]), 32'(mv[v]));
        check($sformatf("mode%0d_miso_%0d", idx, v),
              mrx[0], 32'(stx[v]));
        check($sformatf("mode%0d_vcnt_%0d", idx, v),
              32'(vcnt[idx] - c0), 32'd1);
      end
    end

    // Underrun: two-word frame with nothing queued
    mtx[0] = 32'h11;
    mtx[1] = 32'h22;
    c0 = vcnt[0];
    frame(0, 1'b0, 8, 1'b1, 2, 8);
    check("ur_word0", mrx[0], 32'hFF);
    check("ur_word1", mrx[1], 32'hFF);
    check("ur_vcnt", 32'(vcnt[0] - c0), 32'd2);
    check("ur_rx_data", 32'(rxd8[0]), 32'h22);
    check("ur_sticky", 32'(und[0]), 32'd1);
    load(0, 32'h00);
    check("ur_cleared", 32'(und[0]), 32'd0);

    // Partial word then a fresh frame
    mtx[0] = 32'hF0;
    c0 = vcnt[0];
    frame(0, 1'b0, 8, 1'b1, 1, 5);
    check("part_vcnt", 32'(vcnt[0] - c0), 32'd0);
    check("part_rx_data", 32'(rxd8[0]), 32'h22);
    mtx[0] = 32'h5A;
    frame(0, 1'b0, 8, 1'b1, 1, 8);
    check("part_new_rx", 32'(rxd8[0]), 32'h5A);
    check("part_new_vcnt", 32'(vcnt[0] - c0), 32'd1);
    check("part_new_miso", mrx[0], 32'hFF);

    // 16-bit back-to-back words
    load(5, 32'hCAFE);
    mtx[0] = 32'h1234;
    mtx[1] = 32'hBEEF;
    mtx[2] = 32'h0001;
    c0 = vcnt[5];
    w16_log.delete();
    fork
      frame(5, 1'b0, 16, 1'b1, 3, 16);
      feed_w16();
    join
    check("w16_vcnt", 32'(vcnt[5] - c0), 32'd3);
    check("w16_log_size", 32'(w16_log.size()), 32'd3);
    if (w16_log.size() == 3) begin
      check("w16_rx0", 32'(w16_log[0]), 32'h1234);
      check("w16_rx1", 32'(w16_log[1]), 32'hBEEF);
      check("w16_rx2", 32'(w16_log[2]), 32'h0001);
    end
    check("w16_miso0", mrx[0], 32'hCAFE);
    check("w16_miso1", mrx[1], 32'h1357);
    check("w16_miso2", mrx[2], 32'h8001);
    check("w16_no_underrun", 32'(und[5]), 32'd0);

    // Reset pulsed mid-word
    c0 = vcnt[0];
    cs_n[0] = 1'b0;
    hw();
    xfer(0, 1'b0, 8, 1'b1, 32'hFF, 3, r);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    reset_outputs("midrst");
    rst = 1'b0;
    xfer(0, 1'b0, 8, 1'b1, 32'hFF, 5, r);
    hw();
    cs_n[0] = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_no_valid", 32'(vcnt[0] - c0), 32'd0);
    check("midrst_rx_kept", 32'(rxd8[0]), 32'd0);
    mtx[0] = 32'h96;
    frame(0, 1'b0, 8, 1'b1, 1, 8);
    check("midrst_new_rx", 32'(rxd8[0]), 32'h96);
    check("midrst_new_vcnt", 32'(vcnt[0] - c0), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
